fx_bus_arb: RTL
===============

Name: fx_bus_arb

Overview:
- Two-master arbiter for the fx register bus.
- Master 0 is the uart commu master; master 1 is an internal master, such as a boot or config sequencer.
- Serialises their write/read commands onto one fx bus master port using round-robin grant.
- Holds the bus for the full read latency and routes the read data back to the master that issued the read.
- Sits between the masters and the fx_bus master port (ufx_*).

Parameters:
- AW, 22, fx address width.
- DW, 8, fx data width.
- RD_LAT, 2, cycles from fx_rd being driven to fx_q being valid; legal range 1..15.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- mN_wr  in  1  master N write command (N=0,1).
- mN_rd  in  1  master N read command.
- mN_waddr  in  AW  master N write address.
- mN_data  in  DW  master N write data.
- mN_raddr  in  AW  master N read address.
- mN_rdy  out  1  command accepted this cycle (combinational).
- mN_q  out  DW  read data returned to master N.
- mN_qvld  out  1  one-cycle strobe: mN_q is valid.
- fx_wr  out  1  bus write strobe.
- fx_waddr  out  AW  bus write address.
- fx_data  out  DW  bus write data.
- fx_rd  out  1  bus read strobe.
- fx_raddr  out  AW  bus read address.
- fx_q  in  DW  bus read data.
- busy  out  1  read lock in progress.

Behaviour:
- Reset values:
  - fx_wr=0, fx_rd=0; fx_waddr, fx_raddr, fx_data = 0.
  - mN_q=0, mN_qvld=0, busy=0.
  - state IDLE; last_grant=1, so m0 wins the first contention.
- Request: reqN = mN_wr | mN_rd. Masters hold the command and its addresses/data stable until the cycle mN_rdy=1.
- Grant, IDLE state only:
  - Only one master requesting: it is granted.
  - Both requesting: the master != last_grant is granted.
  - mN_rdy = (state==IDLE) & grantN & reqN.
  - The non-granted master sees rdy=0 and keeps holding.
- Accept in cycle T:
  - last_grant <= N.
  - fx_wr <= mN_wr; fx_rd <= mN_rd; fx_waddr, fx_data, fx_raddr are registered from master N.
  - All of these are visible in cycle T+1.
  - Strobes are high for exactly one cycle unless another accept occurs in T+1.
- Write-only accept: the state stays IDLE. Back-to-back writes are allowed one per cycle; with both masters writing continuously, grants alternate m0, m1, m0, ...
- Read accept (mN_rd=1, with or without mN_wr in the same cycle):
  - Write and read go out together in T+1 on their separate address buses.
  - state -> RWAIT; owner <= N; cnt <= RD_LAT.
- RWAIT:
  - busy=1 and both rdy=0.
  - cnt decrements once per cycle.
  - In the cycle where cnt==0 (cycle T+1+RD_LAT): mN_q <= fx_q for the owner, mN_qvld <= 1, state -> IDLE.
  - mN_qvld and the new IDLE state are seen in T+2+RD_LAT.
  - A new command may be accepted in that same cycle T+2+RD_LAT.
  - Lock length is RD_LAT+1 cycles.
- Data hold rules:
  - mN_q holds its value until the next read for master N.
  - The non-owner's q/qvld are untouched.
  - fx_* address/data registers hold their last values while the strobes are 0.
- Simultaneous events:
  - Both masters request a read in the same IDLE cycle: one is granted; the other waits through the lock and is granted in cycle T+2+RD_LAT.
  - A request arriving during RWAIT waits; no command is dropped or duplicated.
- Reset mid-read: everything returns to reset values, no qvld is produced, and the command in flight is abandoned.

Test Plan:
- Reset: assert rst 2 cycles with m0_wr=1 -> fx_wr=0, m0_rdy=0, busy=0; first cycle after reset m0_rdy=1.
- m0 write (waddr 22'h010004, data 8'h5A) at T -> m0_rdy=1 at T; fx_wr=1, fx_waddr=22'h010004, fx_data=8'h5A in T+1 only.
- m1 read (raddr 22'h020000) at T, fx_q model returns 8'hC3 at T+3 (RD_LAT=2):
  - fx_rd=1 at T+1.
  - busy=1 during T+1..T+3.
  - m1_q=8'hC3 and m1_qvld=1 at T+4 only.
  - m0_q unchanged.
- Contention: both masters hold writes for 6 cycles from reset -> grant order m0,m1,m0,m1,m0,m1; one fx_wr per cycle with matching addresses.
- Read during lock: m0 reads at T; m1 write held from T+1 -> m1_rdy=0 through T+3, m1_rdy=1 at T+4, fx_wr at T+5.
- Reset during RWAIT (rst at T+2) -> no m0_qvld ever; busy=0 and fx_rd=0 after reset; next read completes normally.

Source files
------------

// File: rtl/fx_bus_arb_if.sv
// Signal bundle between the two fx command masters, the arbiter and the shared fx bus port.
// The arbiter connects through the slave modport; the master modport is the requester/bus-model side.
interface fx_bus_arb_if #(
    parameter int AW = 22,
    parameter int DW = 8
);
    logic          m0_wr;
    logic          m0_rd;
    logic [AW-1:0] m0_waddr;
    logic [DW-1:0] m0_data;
    logic [AW-1:0] m0_raddr;
    logic          m0_rdy;
    logic [DW-1:0] m0_q;
    logic          m0_qvld;

    logic          m1_wr;
    logic          m1_rd;
    logic [AW-1:0] m1_waddr;
    logic [DW-1:0] m1_data;
    logic [AW-1:0] m1_raddr;
    logic          m1_rdy;
    logic [DW-1:0] m1_q;
    logic          m1_qvld;

    logic          fx_wr;
    logic [AW-1:0] fx_waddr;
    logic [DW-1:0] fx_data;
    logic          fx_rd;
    logic [AW-1:0] fx_raddr;
    logic [DW-1:0] fx_q;
    logic          busy;

    modport slave (
        input  m0_wr, m0_rd, m0_waddr, m0_data, m0_raddr,
        output m0_rdy, m0_q, m0_qvld,
        input  m1_wr, m1_rd, m1_waddr, m1_data, m1_raddr,
        output m1_rdy, m1_q, m1_qvld,
        output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        input  fx_q,
        output busy
    );

    modport master (
        output m0_wr, m0_rd, m0_waddr, m0_data, m0_raddr,
        input  m0_rdy, m0_q, m0_qvld,
        output m1_wr, m1_rd, m1_waddr, m1_data, m1_raddr,
        input  m1_rdy, m1_q, m1_qvld,
        input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        output fx_q,
        input  busy
    );
endinterface

// File: rtl/fx_bus_arb.sv
// Two-master round-robin arbiter for the fx register bus. A read locks the bus for RD_LAT+1
// cycles; the fx_q sample taken at the end of the lock is returned only to the issuing master.
module fx_bus_arb #(
    parameter int AW     = 22,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic        clk_sys,
    input  logic        rst,
    fx_bus_arb_if.slave bus
);
    localparam int NM = 2;
    localparam int CW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        RWAIT = 1'b1
    } state_t;

    logic [NM-1:0]         m_wr;
    logic [NM-1:0]         m_rd;
    logic [NM-1:0]         m_req;
    logic [NM-1:0][AW-1:0] m_waddr;
    logic [NM-1:0][AW-1:0] m_raddr;
    logic [NM-1:0][DW-1:0] m_data;
    logic [NM-1:0]         grant;
    logic                  accept;
    logic                  sel;

    state_t        state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          owner_q,      owner_d;
    logic          last_grant_q, last_grant_d;
    logic          fx_wr_q,      fx_wr_d;
    logic          fx_rd_q,      fx_rd_d;
    logic [AW-1:0] fx_waddr_q,   fx_waddr_d;
    logic [AW-1:0] fx_raddr_q,   fx_raddr_d;
    logic [DW-1:0] fx_data_q,    fx_data_d;

    assign m_wr    = {bus.m1_wr,    bus.m0_wr};
    assign m_rd    = {bus.m1_rd,    bus.m0_rd};
    assign m_waddr = {bus.m1_waddr, bus.m0_waddr};
    assign m_raddr = {bus.m1_raddr, bus.m0_raddr};
    assign m_data  = {bus.m1_data,  bus.m0_data};
    assign m_req   = m_wr | m_rd;

    // On contention the master that did not win last time goes first; nothing is granted in reset.
    always_comb begin
        grant = '0;
        if (!rst && state_q == IDLE) begin
            if (m_req[0] && (!m_req[1] || last_grant_q)) begin
                grant[0] = 1'b1;
            end else if (m_req[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    assign accept = |grant;
    assign sel    = grant[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        fx_wr_d      = 1'b0;
        fx_rd_d      = 1'b0;
        fx_waddr_d   = fx_waddr_q;
        fx_raddr_d   = fx_raddr_q;
        fx_data_d    = fx_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = sel;
                    fx_wr_d      = m_wr[sel];
                    fx_rd_d      = m_rd[sel];
                    fx_waddr_d   = m_waddr[sel];
                    fx_raddr_d   = m_raddr[sel];
                    fx_data_d    = m_data[sel];
                    if (m_rd[sel]) begin
                        state_d = RWAIT;
                        owner_d = sel;
                        cnt_d   = CW'(RD_LAT);
                    end
                end
            end
            RWAIT: begin
                // cnt reaches zero in the cycle fx_q is valid; the return path samples it then.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            fx_wr_q      <= 1'b0;
            fx_rd_q      <= 1'b0;
            fx_waddr_q   <= '0;
            fx_raddr_q   <= '0;
            fx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            fx_wr_q      <= fx_wr_d;
            fx_rd_q      <= fx_rd_d;
            fx_waddr_q   <= fx_waddr_d;
            fx_raddr_q   <= fx_raddr_d;
            fx_data_q    <= fx_data_d;
        end
    end

    // Per-master read return: only the lock owner's q/qvld ever change.
    for (genvar gi = 0; gi < NM; gi++) begin : g_rdq
        logic          capture;
        logic [DW-1:0] q_q,    q_d;
        logic          qvld_q, qvld_d;

        assign capture = (state_q == RWAIT) && (cnt_q == '0) && (owner_q == 1'(gi));

        always_comb begin
            q_d    = q_q;
            qvld_d = capture;
            if (capture) begin
                q_d = bus.fx_q;
            end
        end

        always_ff @(posedge clk_sys) begin
            if (rst) begin
                q_q    <= '0;
                qvld_q <= 1'b0;
            end else begin
                q_q    <= q_d;
                qvld_q <= qvld_d;
            end
        end
    end

    assign bus.m0_rdy   = grant[0];
    assign bus.m1_rdy   = grant[1];
    assign bus.m0_q     = g_rdq[0].q_q;
    assign bus.m0_qvld  = g_rdq[0].qvld_q;
    assign bus.m1_q     = g_rdq[1].q_q;
    assign bus.m1_qvld  = g_rdq[1].qvld_q;
    assign bus.fx_wr    = fx_wr_q;
    assign bus.fx_rd    = fx_rd_q;
    assign bus.fx_waddr = fx_waddr_q;
    assign bus.fx_raddr = fx_raddr_q;
    assign bus.fx_data  = fx_data_q;
    assign bus.busy     = (state_q == RWAIT);

endmodule
